edge_detector_mc: RTL and testbench
===================================

Name: edge_detector_mc

Overview:
- Multi-channel successor to the single-signal edge detector.
- Each channel has a configurable-depth synchroniser and a counter-based debounce filter. It outputs the filtered level plus one-cycle rising, falling and any-edge pulses.
- Sits between asynchronous board inputs (keys, UART/flash status lines) and the control FSMs, all in the single system clock domain.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering).
- INIT_LEVEL, 1'b0: reset value of the synchroniser flops and filtered level, for all channels.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  CHANNELS  raw asynchronous inputs.
- level_out  out  CHANNELS  debounced, registered level.
- posedge_out  out  CHANNELS  one-cycle pulse on accepted 0->1 change.
- negedge_out  out  CHANNELS  one-cycle pulse on accepted 1->0 change.
- anyedge_out  out  CHANNELS  posedge_out | negedge_out (combinational OR of registered pulses).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: sync flops = INIT_LEVEL; level_out = INIT_LEVEL; debounce counters = 0; all pulse outputs = 0.
- Reset is async assert, sync deassert is external. Reset mid-count discards the count immediately.
- Synchroniser: shift chain of SYNC_STAGES flops per channel. The last stage is s[i].
- Per-channel FSM has two states:
  - STABLE: s == level. Counter held at 0.
  - PENDING: s != level. Counter increments each cycle.
- Transitions:
  - STABLE -> PENDING when s != level.
  - PENDING -> STABLE (counter cleared, no pulse) if s returns to level before acceptance.
  - PENDING -> STABLE with acceptance when counter == DEBOUNCE_CYCLES-1 and s still != level.
- On acceptance: in the same clock edge, level toggles and exactly one of posedge/negedge is registered high for one cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). Counter never wraps; it saturates at acceptance and is cleared.
- Latency: a sig_in change held stable reaches level_out and the pulse SYNC_STAGES + DEBOUNCE_CYCLES rising edges after it is first sampled.
- Pulses never exceed one cycle. Minimum spacing between two edges on one channel is DEBOUNCE_CYCLES cycles.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.
- Inputs already at INIT_LEVEL after reset produce no pulse. Inputs differing from INIT_LEVEL produce an edge pulse after the normal latency.

Optional Feature:
- Macro: EDGE_DETECTOR_STICKY_EN.
- When defined, adds:
  - input evt_clr[CHANNELS]
  - output evt_flag[CHANNELS], reset 0.
- evt_flag[i] is set on any accepted edge of channel i and cleared by evt_clr[i] one cycle later.
- Set wins over clear in the same cycle.
- When undefined: both ports and the flag logic are absent; no other behaviour changes.

Decomposition:
- Package edge_detector_pkg holds:
  - the counter-width function (clog2-based);
  - the FSM state encoding constants ST_STABLE / ST_PENDING;
  - default parameter constants.
- Sub-module edge_chan implements one channel (synchroniser, FSM, counter, pulses, optional flag). The top instantiates it CHANNELS times in a generate loop and concatenates the outputs.

Test Plan:
All scenarios use CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0 unless stated.
1. rst_n=0 with sig_in=4'hF, then release -> outputs 0 during reset. After the 6th edge, level_out=4'hF and posedge_out=4'hF for exactly 1 cycle; negedge_out stays 0.
2. Glitch: sig_in[0] high for 3 cycles then low -> level_out[0] stays 0 and no pulses. Held high for 4 or more cycles -> posedge_out[0] pulses once.
3. Simultaneous events: from level 4'b0100, ch1 rises and ch2 falls in the same cycle -> in one cycle, posedge_out=4'b0010, negedge_out=4'b0100, anyedge_out=4'b0110.
4. Reset mid-operation: assert rst_n=0 when the ch3 counter=3 -> level_out, pulses and counter go to 0 immediately, without a clock. After release, a new full 6-cycle latency applies.
5. EDGE_DETECTOR_STICKY_EN: after an edge sets evt_flag[0]=1, pulse evt_clr[0] in the same cycle as a new edge -> flag remains 1. A later clear alone gives flag=0.
6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3 instance: a step on sig_in[2] gives level_out[2] and posedge_out[2] after exactly 4 edges; a 1-cycle pulse is passed through as a rise then a fall.

Source files
------------

// File: rtl/edge_detector_mc_pkg.sv
// Shared types and constants for the multi-channel edge detector.
// Used by every build; the optional sticky flag is EDGE_DETECTOR_STICKY_EN.
package edge_detector_pkg;

  localparam int unsigned DEF_CHANNELS        = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam logic        DEF_INIT_LEVEL      = 1'b0;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_e;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_out_t;

  function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_detector_mc_if.sv
// Channel bus between the raw inputs and the edge detector outputs.
// Optional evt_clr/evt_flag are present only with EDGE_DETECTOR_STICKY_EN.
interface edge_detector_mc_if
  import edge_detector_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS
);

  logic [CHANNELS-1:0] sig_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] posedge_out;
  logic [CHANNELS-1:0] negedge_out;
  logic [CHANNELS-1:0] anyedge_out;
`ifdef EDGE_DETECTOR_STICKY_EN
  logic [CHANNELS-1:0] evt_clr;
  logic [CHANNELS-1:0] evt_flag;
`endif

  modport master (
`ifdef EDGE_DETECTOR_STICKY_EN
    output evt_clr,
    input  evt_flag,
`endif
    output sig_in,
    input  level_out,
    input  posedge_out,
    input  negedge_out,
    input  anyedge_out
  );

  modport slave (
`ifdef EDGE_DETECTOR_STICKY_EN
    input  evt_clr,
    output evt_flag,
`endif
    input  sig_in,
    output level_out,
    output posedge_out,
    output negedge_out,
    output anyedge_out
  );

endinterface

// File: rtl/edge_detector_mc_chan.sv
// One channel: synchroniser chain, debounce FSM/counter and edge pulses.
// The sticky event flag is built only with EDGE_DETECTOR_STICKY_EN.
module edge_chan
  import edge_detector_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        INIT_LEVEL      = DEF_INIT_LEVEL
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_sig,
`ifdef EDGE_DETECTOR_STICKY_EN
  input  logic      i_evt_clr,
  output logic      o_evt_flag,
`endif
  output chan_out_t o_out
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  chan_state_e            r_state;
  chan_state_e            w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_accept;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser: newest sample enters at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= INIT_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= r_level ^ w_accept;
      r_rise  <= w_accept & ~r_level;
      r_fall  <= w_accept & r_level;
    end
  end

  // Acceptance fires once the new level has been seen DEBOUNCE_CYCLES times in a row.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_STABLE: begin
        if (w_s != r_level) begin
          if (r_cnt == CNT_LAST) begin
            w_accept  = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_PENDING;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_PENDING: begin
        if (w_s == r_level) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

`ifdef EDGE_DETECTOR_STICKY_EN
  logic r_flag;

  // A new edge overrides a clear arriving on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_flag <= 1'b0;
    else if (w_accept)  r_flag <= 1'b1;
    else if (i_evt_clr) r_flag <= 1'b0;
  end

  assign o_evt_flag = r_flag;
`endif

  assign o_out = '{level: r_level, rise: r_rise, fall: r_fall};

endmodule

// File: rtl/edge_detector_mc.sv
// Multi-channel debounced edge detector: CHANNELS independent edge_chan instances.
// Define EDGE_DETECTOR_STICKY_EN to add per-channel sticky event flags.
module edge_detector_mc
  import edge_detector_pkg::*;
#(
  parameter int unsigned CHANNELS        = DEF_CHANNELS,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        INIT_LEVEL      = DEF_INIT_LEVEL
) (
  input logic               clk,
  input logic               rst_n,
  edge_detector_mc_if.slave bus
);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
`ifdef EDGE_DETECTOR_STICKY_EN
  logic [CHANNELS-1:0] w_flag;
`endif

  for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_chan
    chan_out_t w_out;

    edge_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_LEVEL      (INIT_LEVEL)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sig      (bus.sig_in[gi]),
`ifdef EDGE_DETECTOR_STICKY_EN
      .i_evt_clr  (bus.evt_clr[gi]),
      .o_evt_flag (w_flag[gi]),
`endif
      .o_out      (w_out)
    );

    assign w_level[gi] = w_out.level;
    assign w_rise[gi]  = w_out.rise;
    assign w_fall[gi]  = w_out.fall;
  end

  assign bus.level_out   = w_level;
  assign bus.posedge_out = w_rise;
  assign bus.negedge_out = w_fall;
  assign bus.anyedge_out = w_rise | w_fall;
`ifdef EDGE_DETECTOR_STICKY_EN
  assign bus.evt_flag    = w_flag;
`endif

endmodule

// File: tb/tb_edge_detector_mc.sv
// Bench for edge_detector_mc: directed scenarios plus random traffic against a history-based model.
// Covers the EDGE_DETECTOR_STICKY_EN flag when that macro is defined.
module tb_edge_detector_mc;

  localparam int unsigned CH = 4;
  localparam int unsigned S1 = 2;
  localparam int unsigned D1 = 4;
  localparam int unsigned S2 = 3;
  localparam int unsigned D2 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  edge_detector_mc_if #(.CHANNELS(CH)) bus1 ();
  edge_detector_mc_if #(.CHANNELS(CH)) bus2 ();

  edge_detector_mc #(
    .CHANNELS(CH), .SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1), .INIT_LEVEL(1'b0)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  edge_detector_mc #(
    .CHANNELS(CH), .SYNC_STAGES(S2), .DEBOUNCE_CYCLES(D2), .INIT_LEVEL(1'b0)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // Model: a level is accepted once the last `deb` synchronised samples all differ from it.
  function automatic logic [CH-1:0] accept_of(input logic [CH-1:0] sq[$],
                                              input logic [CH-1:0] lvl,
                                              input int unsigned deb);
    logic [CH-1:0] acc;
    if (sq.size() != int'(deb)) return '0;
    acc = '1;
    foreach (sq[j]) acc = acc & (sq[j] ^ lvl);
    return acc;
  endfunction

  logic [CH-1:0] m1_in_q[$], m1_s_q[$], m2_in_q[$], m2_s_q[$];
  logic [CH-1:0] m1_level, m1_pos, m1_neg, m1_flag;
  logic [CH-1:0] m2_level, m2_pos, m2_neg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_in_q.delete(); m1_s_q.delete();
      m1_level <= '0; m1_pos <= '0; m1_neg <= '0; m1_flag <= '0;
    end else begin
      m1_in_q.push_back(bus1.sig_in);
      if (m1_in_q.size() > int'(S1 + 1)) void'(m1_in_q.pop_front());
      m1_s_q.push_back((m1_in_q.size() > int'(S1)) ? m1_in_q[0] : '0);
      if (m1_s_q.size() > int'(D1)) void'(m1_s_q.pop_front());
      m1_level <= m1_level ^ accept_of(m1_s_q, m1_level, D1);
      m1_pos   <= accept_of(m1_s_q, m1_level, D1) & ~m1_level;
      m1_neg   <= accept_of(m1_s_q, m1_level, D1) & m1_level;
`ifdef EDGE_DETECTOR_STICKY_EN
      m1_flag  <= accept_of(m1_s_q, m1_level, D1) | (m1_flag & ~bus1.evt_clr);
`endif
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_in_q.delete(); m2_s_q.delete();
      m2_level <= '0; m2_pos <= '0; m2_neg <= '0;
    end else begin
      m2_in_q.push_back(bus2.sig_in);
      if (m2_in_q.size() > int'(S2 + 1)) void'(m2_in_q.pop_front());
      m2_s_q.push_back((m2_in_q.size() > int'(S2)) ? m2_in_q[0] : '0);
      if (m2_s_q.size() > int'(D2)) void'(m2_s_q.pop_front());
      m2_level <= m2_level ^ accept_of(m2_s_q, m2_level, D2);
      m2_pos   <= accept_of(m2_s_q, m2_level, D2) & ~m2_level;
      m2_neg   <= accept_of(m2_s_q, m2_level, D2) & m2_level;
    end
  end

  task automatic test_reset();
    logic [CH-1:0] exp_lvl, exp_pos;
    #1 rst_n = 1'b0;
    bus1.sig_in = 4'hF;
    bus2.sig_in = 4'h0;
    @(negedge clk);
    checks++;
    if ({bus1.level_out, bus1.posedge_out, bus1.negedge_out, bus1.anyedge_out} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000",
               {bus1.level_out, bus1.posedge_out, bus1.negedge_out, bus1.anyedge_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 6) ? 4'hF : 4'h0;
      exp_pos = (k == 6) ? 4'hF : 4'h0;
      checks++;
      if (bus1.level_out !== exp_lvl) begin
        errors++; $display("FAIL reset_latency_level edge%0d: got %h want %h", k, bus1.level_out, exp_lvl);
      end
      checks++;
      if (bus1.posedge_out !== exp_pos) begin
        errors++; $display("FAIL reset_latency_pos edge%0d: got %h want %h", k, bus1.posedge_out, exp_pos);
      end
      checks++;
      if (bus1.negedge_out !== 4'h0) begin
        errors++; $display("FAIL reset_latency_neg edge%0d: got %h want 0", k, bus1.negedge_out);
      end
    end
  endtask

  task automatic test_glitch();
    int rises, falls;
    bus1.sig_in = 4'h0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus1.level_out !== 4'h0) begin
      errors++; $display("FAIL glitch_settle: got %h want 0", bus1.level_out);
    end
    rises = 0;
    bus1.sig_in = 4'h1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 2) bus1.sig_in = 4'h0;
      rises += int'(bus1.posedge_out[0]);
    end
    checks++;
    if (rises != 0 || bus1.level_out[0] !== 1'b0) begin
      errors++; $display("FAIL glitch_3cyc: got rises=%0d level=%b want 0/0", rises, bus1.level_out[0]);
    end
    rises = 0; falls = 0;
    bus1.sig_in = 4'h1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 3) bus1.sig_in = 4'h0;
      rises += int'(bus1.posedge_out[0]);
      falls += int'(bus1.negedge_out[0]);
    end
    checks++;
    if (rises != 1 || falls != 1) begin
      errors++; $display("FAIL glitch_4cyc: got rises=%0d falls=%0d want 1/1", rises, falls);
    end
  endtask

  task automatic test_simultaneous();
    int hits, at;
    logic [CH-1:0] cap_pos, cap_neg, cap_any;
    bus1.sig_in = 4'b0100;
    repeat (8) @(negedge clk);
    checks++;
    if (bus1.level_out !== 4'b0100) begin
      errors++; $display("FAIL simul_setup: got %b want 0100", bus1.level_out);
    end
    hits = 0; at = 0; cap_pos = '0; cap_neg = '0; cap_any = '0;
    bus1.sig_in = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus1.anyedge_out != 4'h0) begin
        hits++; at = k;
        cap_pos = bus1.posedge_out; cap_neg = bus1.negedge_out; cap_any = bus1.anyedge_out;
      end
    end
    checks++;
    if (hits != 1 || at != 6) begin
      errors++; $display("FAIL simul_timing: got cycles=%0d at=%0d want 1 at 6", hits, at);
    end
    checks++;
    if ({cap_pos, cap_neg, cap_any} !== {4'b0010, 4'b0100, 4'b0110}) begin
      errors++; $display("FAIL simul_pulses: got pos=%b neg=%b any=%b want 0010/0100/0110",
                         cap_pos, cap_neg, cap_any);
    end
  endtask

  task automatic test_mid_reset();
    logic [CH-1:0] exp_lvl, exp_pos;
    bus1.sig_in = 4'b0001;
    repeat (8) @(negedge clk);
    checks++;
    if (bus1.level_out !== 4'b0001) begin
      errors++; $display("FAIL midrst_setup: got %b want 0001", bus1.level_out);
    end
    bus1.sig_in = 4'b1001;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.level_out, bus1.posedge_out, bus1.negedge_out} !== 12'h0) begin
      errors++; $display("FAIL midrst_async: got %h want 000",
                         {bus1.level_out, bus1.posedge_out, bus1.negedge_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 6) ? 4'b1001 : 4'b0000;
      exp_pos = (k == 6) ? 4'b1001 : 4'b0000;
      checks++;
      if (bus1.level_out !== exp_lvl || bus1.posedge_out !== exp_pos) begin
        errors++; $display("FAIL midrst_relatch edge%0d: got lvl=%b pos=%b want %b/%b",
                           k, bus1.level_out, bus1.posedge_out, exp_lvl, exp_pos);
      end
    end
  endtask

  task automatic test_fast_channel();
    logic exp_lvl, exp_pos, exp_neg;
    bus2.sig_in = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus2.level_out[2] !== (k >= 4) || bus2.posedge_out[2] !== (k == 4)) begin
        errors++; $display("FAIL fast_step edge%0d: got lvl=%b pos=%b want %b/%b",
                           k, bus2.level_out[2], bus2.posedge_out[2], k >= 4, k == 4);
      end
    end
    bus2.sig_in = 4'b0000;
    repeat (6) @(negedge clk);
    bus2.sig_in = 4'b0100;
    @(negedge clk);
    bus2.sig_in = 4'b0000;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      exp_lvl = (k == 4); exp_pos = (k == 4); exp_neg = (k == 5);
      checks++;
      if ({bus2.level_out[2], bus2.posedge_out[2], bus2.negedge_out[2]} !== {exp_lvl, exp_pos, exp_neg}) begin
        errors++; $display("FAIL fast_pulse edge%0d: got %b%b%b want %b%b%b", k,
                           bus2.level_out[2], bus2.posedge_out[2], bus2.negedge_out[2],
                           exp_lvl, exp_pos, exp_neg);
      end
    end
  endtask

`ifdef EDGE_DETECTOR_STICKY_EN
  task automatic test_sticky();
    bus1.sig_in = 4'h0;
    repeat (8) @(negedge clk);
    bus1.evt_clr = 4'hF;
    @(negedge clk);
    bus1.evt_clr = 4'h0;
    checks++;
    if (bus1.evt_flag !== 4'h0) begin
      errors++; $display("FAIL sticky_clear_all: got %b want 0000", bus1.evt_flag);
    end
    bus1.sig_in = 4'h1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus1.evt_flag[0] !== 1'b1 || bus1.posedge_out[0] !== 1'b1) begin
      errors++; $display("FAIL sticky_set: got flag=%b pos=%b want 1/1", bus1.evt_flag[0], bus1.posedge_out[0]);
    end
    bus1.sig_in = 4'h0;
    repeat (5) @(negedge clk);
    bus1.evt_clr = 4'h1;
    @(negedge clk);
    bus1.evt_clr = 4'h0;
    checks++;
    if (bus1.evt_flag[0] !== 1'b1 || bus1.negedge_out[0] !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins: got flag=%b neg=%b want 1/1", bus1.evt_flag[0], bus1.negedge_out[0]);
    end
    @(negedge clk);
    bus1.evt_clr = 4'h1;
    @(negedge clk);
    bus1.evt_clr = 4'h0;
    checks++;
    if (bus1.evt_flag[0] !== 1'b0) begin
      errors++; $display("FAIL sticky_clear: got %b want 0", bus1.evt_flag[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({bus1.level_out, bus1.posedge_out, bus1.negedge_out, bus1.anyedge_out} !==
          {m1_level, m1_pos, m1_neg, m1_pos | m1_neg}) begin
        errors++; $display("FAIL rand_dut1 cyc%0d: got %h want %h", i,
                           {bus1.level_out, bus1.posedge_out, bus1.negedge_out, bus1.anyedge_out},
                           {m1_level, m1_pos, m1_neg, m1_pos | m1_neg});
      end
      checks++;
      if ({bus2.level_out, bus2.posedge_out, bus2.negedge_out, bus2.anyedge_out} !==
          {m2_level, m2_pos, m2_neg, m2_pos | m2_neg}) begin
        errors++; $display("FAIL rand_dut2 cyc%0d: got %h want %h", i,
                           {bus2.level_out, bus2.posedge_out, bus2.negedge_out, bus2.anyedge_out},
                           {m2_level, m2_pos, m2_neg, m2_pos | m2_neg});
      end
`ifdef EDGE_DETECTOR_STICKY_EN
      checks++;
      if (bus1.evt_flag !== m1_flag) begin
        errors++; $display("FAIL rand_flag cyc%0d: got %b want %b", i, bus1.evt_flag, m1_flag);
      end
      bus1.evt_clr = CH'($urandom_range(0, 15) & $urandom_range(0, 15));
`endif
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 4) == 0) bus1.sig_in[c] = ~bus1.sig_in[c];
        if ($urandom_range(0, 2) == 0) bus2.sig_in[c] = ~bus2.sig_in[c];
      end
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    bus1.sig_in = '0;
    bus2.sig_in = '0;
`ifdef EDGE_DETECTOR_STICKY_EN
    bus1.evt_clr = '0;
    bus2.evt_clr = '0;
`endif
    test_reset();
    test_glitch();
    test_simultaneous();
    test_mid_reset();
    test_fast_channel();
`ifdef EDGE_DETECTOR_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
